// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone bridge arbiters: bus-owner encoding
// and the default timeout width.
package wb_bridge_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_IDLE  = 2'd0;
    localparam owner_t OWN_RD    = 2'd1;
    localparam owner_t OWN_WR    = 2'd2;
    localparam owner_t OWN_ABORT = 2'd3;

    localparam int DEFAULT_LGTIMEOUT = 6;

endpackage

// File: rtl/wb_rdwr_arbiter_if.sv
// Bundle of the read-bridge, write-bridge and shared-bus signals of the
// read/write arbiter, for benches and wrappers that carry them as one port.
interface wb_rdwr_arbiter_if #(
    parameter int AW = 26,
    parameter int DW = 32
);
    logic            i_rd_cyc;
    logic            i_rd_stb;
    logic [AW-1:0]   i_rd_addr;
    logic [DW/8-1:0] i_rd_sel;
    logic            o_rd_stall;
    logic            o_rd_ack;
    logic            o_rd_err;
    logic [DW-1:0]   o_rd_data;

    logic            i_wr_cyc;
    logic            i_wr_stb;
    logic [AW-1:0]   i_wr_addr;
    logic [DW-1:0]   i_wr_data;
    logic [DW/8-1:0] i_wr_sel;
    logic            o_wr_stall;
    logic            o_wr_ack;
    logic            o_wr_err;

    logic            o_wb_cyc;
    logic            o_wb_stb;
    logic            o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic            i_wb_stall;
    logic            i_wb_ack;
    logic            i_wb_err;
    logic [DW-1:0]   i_wb_data;

    // Arbiter view: it masters the shared bus and answers both bridges.
    modport master (
        input  i_rd_cyc, i_rd_stb, i_rd_addr, i_rd_sel,
        output o_rd_stall, o_rd_ack, o_rd_err, o_rd_data,
        input  i_wr_cyc, i_wr_stb, i_wr_addr, i_wr_data, i_wr_sel,
        output o_wr_stall, o_wr_ack, o_wr_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

    // Environment view: the two bridges plus the downstream slave.
    modport slave (
        output i_rd_cyc, i_rd_stb, i_rd_addr, i_rd_sel,
        input  o_rd_stall, o_rd_ack, o_rd_err, o_rd_data,
        output i_wr_cyc, i_wr_stb, i_wr_addr, i_wr_data, i_wr_sel,
        input  o_wr_stall, o_wr_ack, o_wr_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

endinterface

// File: rtl/wb_rdwr_arbiter.sv
// Two-port Wishbone arbiter: a read bridge and a write bridge share one bus,
// alternating on contention, with a bus-timeout that errors and aborts the owner.
module wb_rdwr_arbiter
    import wb_bridge_pkg::*;
#(
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int LGTIMEOUT = DEFAULT_LGTIMEOUT
) (
    input  logic            i_clk,
    input  logic            i_axi_reset_n,
    input  logic            i_rd_cyc,
    input  logic            i_rd_stb,
    input  logic [AW-1:0]   i_rd_addr,
    input  logic [DW/8-1:0] i_rd_sel,
    output logic            o_rd_stall,
    output logic            o_rd_ack,
    output logic            o_rd_err,
    output logic [DW-1:0]   o_rd_data,
    input  logic            i_wr_cyc,
    input  logic            i_wr_stb,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [DW-1:0]   i_wr_data,
    input  logic [DW/8-1:0] i_wr_sel,
    output logic            o_wr_stall,
    output logic            o_wr_ack,
    output logic            o_wr_err,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    // Error fires on the wait cycle that brings the count to 2**LGTIMEOUT-1.
    localparam logic [LGTIMEOUT-1:0] TIMEOUT_LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

    owner_t               state_reg, state_next;
    logic [LGTIMEOUT-1:0] count_reg, count_next;
    logic                 last_wr_reg, last_wr_next;

    logic own_rd, own_wr;
    logic bus_wait, timeout, bus_err;

    assign own_rd = (state_reg == OWN_RD);
    assign own_wr = (state_reg == OWN_WR);

    always_comb begin
        o_wb_cyc  = (own_rd & i_rd_cyc) | (own_wr & i_wr_cyc);
        o_wb_stb  = (own_rd & i_rd_stb) | (own_wr & i_wr_stb);
        o_wb_we   = own_wr;
        o_wb_addr = own_wr ? i_wr_addr : (own_rd ? i_rd_addr : '0);
        o_wb_sel  = own_wr ? i_wr_sel  : (own_rd ? i_rd_sel  : '0);
        o_wb_data = own_wr ? i_wr_data : '0;
    end

    assign bus_wait = o_wb_cyc & ~i_wb_ack & ~i_wb_err;
    assign timeout  = o_wb_cyc & ~i_wb_ack & (count_reg == TIMEOUT_LAST);
    // A real bus error and a timeout in the same cycle merge into one pulse.
    assign bus_err  = o_wb_cyc & (i_wb_err | timeout);

    assign o_rd_stall = own_rd ? i_wb_stall : 1'b1;
    assign o_wr_stall = own_wr ? i_wb_stall : 1'b1;
    assign o_rd_ack   = own_rd & o_wb_cyc & i_wb_ack;
    assign o_wr_ack   = own_wr & o_wb_cyc & i_wb_ack;
    assign o_rd_err   = own_rd & bus_err;
    assign o_wr_err   = own_wr & bus_err;
    assign o_rd_data  = i_wb_data;

    always_comb begin
        state_next   = state_reg;
        last_wr_next = last_wr_reg;
        count_next   = bus_wait ? count_reg + 1'b1 : '0;
        case (state_reg)
            OWN_IDLE: begin
                if (i_rd_cyc && (!i_wr_cyc || last_wr_reg)) begin
                    state_next   = OWN_RD;
                    last_wr_next = 1'b0;
                end else if (i_wr_cyc) begin
                    state_next   = OWN_WR;
                    last_wr_next = 1'b1;
                end
            end
            OWN_RD: begin
                if (timeout)
                    state_next = OWN_ABORT;
                else if (!i_rd_cyc)
                    state_next = OWN_IDLE;
            end
            OWN_WR: begin
                if (timeout)
                    state_next = OWN_ABORT;
                else if (!i_wr_cyc)
                    state_next = OWN_IDLE;
            end
            default: begin
                // The aborted owner is the one granted last; wait for it to let go.
                if (last_wr_reg ? !i_wr_cyc : !i_rd_cyc)
                    state_next = OWN_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_axi_reset_n) begin
            state_reg   <= OWN_IDLE;
            count_reg   <= '0;
            last_wr_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            last_wr_reg <= last_wr_next;
        end
    end

endmodule

// File: tb/tb_wb_rdwr_arbiter.sv
// Bench for wb_rdwr_arbiter: directed scenarios plus random traffic, every
// output checked each cycle against a behavioural ownership model.
module tb_wb_rdwr_arbiter;

    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int LG    = 4;
    localparam int LIMIT = (1 << LG) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_rdwr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wb_rdwr_arbiter #(.AW(AW), .DW(DW), .LGTIMEOUT(LG)) dut (
        .i_clk(clk), .i_axi_reset_n(rst_n),
        .i_rd_cyc(bus.i_rd_cyc), .i_rd_stb(bus.i_rd_stb), .i_rd_addr(bus.i_rd_addr),
        .i_rd_sel(bus.i_rd_sel), .o_rd_stall(bus.o_rd_stall), .o_rd_ack(bus.o_rd_ack),
        .o_rd_err(bus.o_rd_err), .o_rd_data(bus.o_rd_data),
        .i_wr_cyc(bus.i_wr_cyc), .i_wr_stb(bus.i_wr_stb), .i_wr_addr(bus.i_wr_addr),
        .i_wr_data(bus.i_wr_data), .i_wr_sel(bus.i_wr_sel), .o_wr_stall(bus.o_wr_stall),
        .o_wr_ack(bus.o_wr_ack), .o_wr_err(bus.o_wr_err),
        .o_wb_cyc(bus.o_wb_cyc), .o_wb_stb(bus.o_wb_stb), .o_wb_we(bus.o_wb_we),
        .o_wb_addr(bus.o_wb_addr), .o_wb_data(bus.o_wb_data), .o_wb_sel(bus.o_wb_sel),
        .i_wb_stall(bus.i_wb_stall), .i_wb_ack(bus.i_wb_ack), .i_wb_err(bus.i_wb_err),
        .i_wb_data(bus.i_wb_data)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: who holds the bus, how long it has waited silently.
    typedef enum int {M_NONE, M_READER, M_WRITER, M_ABORTED} m_owner_e;
    m_owner_e m_owner;
    bit       m_aborted_wr;
    bit       m_prev_wr;
    int       m_waited;
    bit       m_known = 1'b0;

    // Checks the current cycle against the model, then advances it across one edge.
    task automatic step();
        bit on_rd, on_wr, bus_on, bus_stb, expire, any_err, grant_wr;
        #1;
        on_rd   = (m_owner == M_READER);
        on_wr   = (m_owner == M_WRITER);
        bus_on  = on_rd ? bus.i_rd_cyc : (on_wr ? bus.i_wr_cyc : 1'b0);
        bus_stb = on_rd ? bus.i_rd_stb : (on_wr ? bus.i_wr_stb : 1'b0);
        expire  = bus_on && !bus.i_wb_ack && (m_waited + 1 >= LIMIT);
        any_err = bus_on && (bus.i_wb_err || expire);
        if (m_known) begin
            check("wb_cyc",   bus.o_wb_cyc,   bus_on);
            check("wb_stb",   bus.o_wb_stb,   bus_stb);
            check("wb_we",    bus.o_wb_we,    on_wr);
            check("wb_addr",  bus.o_wb_addr,  on_wr ? bus.i_wr_addr : (on_rd ? bus.i_rd_addr : '0));
            check("wb_sel",   bus.o_wb_sel,   on_wr ? bus.i_wr_sel  : (on_rd ? bus.i_rd_sel  : '0));
            check("wb_data",  bus.o_wb_data,  on_wr ? bus.i_wr_data : '0);
            check("rd_data",  bus.o_rd_data,  bus.i_wb_data);
            check("rd_stall", bus.o_rd_stall, on_rd ? bus.i_wb_stall : 1'b1);
            check("wr_stall", bus.o_wr_stall, on_wr ? bus.i_wb_stall : 1'b1);
            check("rd_ack",   bus.o_rd_ack,   on_rd && bus_on && bus.i_wb_ack);
            check("wr_ack",   bus.o_wr_ack,   on_wr && bus_on && bus.i_wb_ack);
            check("rd_err",   bus.o_rd_err,   on_rd && any_err);
            check("wr_err",   bus.o_wr_err,   on_wr && any_err);
        end
        if (!rst_n) begin
            m_owner   = M_NONE;
            m_waited  = 0;
            m_prev_wr = 1'b1;
            m_known   = 1'b1;
        end else if (m_known) begin
            m_waited = (bus_on && !bus.i_wb_ack && !bus.i_wb_err) ? m_waited + 1 : 0;
            case (m_owner)
                M_NONE: begin
                    if (bus.i_rd_cyc || bus.i_wr_cyc) begin
                        grant_wr  = (bus.i_rd_cyc && bus.i_wr_cyc) ? !m_prev_wr : bus.i_wr_cyc;
                        m_owner   = grant_wr ? M_WRITER : M_READER;
                        m_prev_wr = grant_wr;
                    end
                end
                M_READER, M_WRITER: begin
                    if (expire) begin
                        m_aborted_wr = on_wr;
                        m_owner      = M_ABORTED;
                    end else if (!bus_on) begin
                        m_owner = M_NONE;
                    end
                end
                default: begin
                    if (m_aborted_wr ? !bus.i_wr_cyc : !bus.i_rd_cyc)
                        m_owner = M_NONE;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.i_rd_cyc = 0; bus.i_rd_stb = 0; bus.i_rd_addr = '0; bus.i_rd_sel = '0;
        bus.i_wr_cyc = 0; bus.i_wr_stb = 0; bus.i_wr_addr = '0; bus.i_wr_sel = '0;
        bus.i_wr_data = '0;
        bus.i_wb_stall = 0; bus.i_wb_ack = 0; bus.i_wb_err = 0; bus.i_wb_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  silent;
        rst_n = 1'b0;
        quiet_inputs();
        @(posedge clk); #1;
        step(); step();
        rst_n = 1'b1;
        step();

        // Read alone at 0x10, slave acks two cycles after the strobe.
        bus.i_rd_cyc = 1; bus.i_rd_stb = 1; bus.i_rd_addr = 26'h10; bus.i_rd_sel = 4'hf;
        step();
        #1; check("rdalone_addr", bus.o_wb_addr, 26'h10);
        step();
        bus.i_rd_stb = 0;
        step();
        bus.i_wb_ack = 1; bus.i_wb_data = 32'hCAFE_0010;
        #1;
        check("rdalone_ack", bus.o_rd_ack, 1'b1);
        check("rdalone_we",  bus.o_wb_we,  1'b0);
        check("rdalone_wr_ack", bus.o_wr_ack, 1'b0);
        step();
        bus.i_wb_ack = 0; bus.i_rd_cyc = 0;
        #1; check("rdalone_ack_once", bus.o_rd_ack, 1'b0);
        step();

        // Simultaneous requests after reset: read first, write after read drops.
        rst_n = 0; step(); rst_n = 1;
        bus.i_rd_cyc = 1; bus.i_rd_stb = 1; bus.i_wr_cyc = 1; bus.i_wr_stb = 1;
        bus.i_wr_addr = 26'h2A; bus.i_wr_data = 32'h1234_5678; bus.i_wr_sel = 4'h3;
        step();
        #1; check("both_rd_first", bus.o_wb_cyc && !bus.o_wb_we, 1'b1);
        bus.i_rd_stb = 0; bus.i_wb_ack = 1;
        step();
        bus.i_wb_ack = 0; bus.i_rd_cyc = 0;
        step();
        #1; check("both_gap_cycle", bus.o_wb_cyc, 1'b0);
        step();
        #1; check("both_wr_next", bus.o_wb_cyc && bus.o_wb_we, 1'b1);

        // Write owns the bus; a read arriving must stay stalled and invisible.
        bus.i_wr_stb = 0; bus.i_rd_cyc = 1; bus.i_rd_stb = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wrown_rd_stall", bus.o_rd_stall, 1'b1);
            check("wrown_no_rdstb", bus.o_wb_stb, 1'b0);
            step();
        end
        bus.i_wb_ack = 1;
        step();
        bus.i_wb_ack = 0; bus.i_wr_cyc = 0;
        step(); step();
        bus.i_rd_cyc = 0; bus.i_rd_stb = 0;
        step();

        // Silent slave: read times out after LIMIT wait cycles, then aborts.
        bus.i_rd_cyc = 1; bus.i_rd_stb = 1;
        step();
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            #1;
            if (bus.o_rd_err) begin k = i; break; end
            step();
            bus.i_rd_stb = 0;
        end
        check("timeout_cycle", k, LIMIT);
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("abort_cyc_low", bus.o_wb_cyc, 1'b0);
            check("abort_no_err", bus.o_rd_err, 1'b0);
            step();
        end
        bus.i_rd_cyc = 0;
        step();

        // Bus error during a write; stray ack while nobody holds the bus.
        bus.i_wr_cyc = 1; bus.i_wr_stb = 1;
        step();
        step();
        bus.i_wr_stb = 0; bus.i_wb_err = 1;
        #1;
        check("wrerr_pulse", bus.o_wr_err, 1'b1);
        check("wrerr_rd_quiet", bus.o_rd_err, 1'b0);
        step();
        bus.i_wb_err = 0; bus.i_wr_cyc = 0;
        step();
        bus.i_wb_ack = 1;
        #1; check("stray_ack", {bus.o_rd_ack, bus.o_wr_ack}, 2'b00);
        step();
        bus.i_wb_ack = 0;
        step();

        // Reset while the writer holds the bus.
        bus.i_wr_cyc = 1; bus.i_wr_stb = 1;
        step();
        #1; check("rstmid_owned", bus.o_wb_cyc, 1'b1);
        rst_n = 0;
        step();
        #1;
        check("rstmid_cyc_drop", bus.o_wb_cyc, 1'b0);
        check("rstmid_no_err", bus.o_wr_err, 1'b0);
        check("rstmid_idle", bus.o_wr_stall, 1'b1);
        rst_n = 1; bus.i_wr_cyc = 0; bus.i_wr_stb = 0;
        step();

        // Random traffic, including silent-slave stretches and stray resets.
        silent = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.i_rd_cyc = ~bus.i_rd_cyc;
            if ($urandom_range(0, 7) == 0) bus.i_wr_cyc = ~bus.i_wr_cyc;
            if ($urandom_range(0, 39) == 0) silent = ~silent;
            bus.i_rd_stb   = bus.i_rd_cyc & 1'($urandom_range(0, 1));
            bus.i_wr_stb   = bus.i_wr_cyc & 1'($urandom_range(0, 1));
            bus.i_rd_addr  = AW'($urandom);
            bus.i_wr_addr  = AW'($urandom);
            bus.i_rd_sel   = 4'($urandom);
            bus.i_wr_sel   = 4'($urandom);
            bus.i_wr_data  = $urandom;
            bus.i_wb_data  = $urandom;
            bus.i_wb_stall = ($urandom_range(0, 3) == 0);
            bus.i_wb_ack   = !silent && ($urandom_range(0, 3) == 0);
            bus.i_wb_err   = !silent && ($urandom_range(0, 15) == 0);
            rst_n          = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
